// File: rtl/pps_channel_scheduler.sv
// Launches and terminates N_CH pps_divider channels on host-scheduled PPS seconds.
// Define PPS_MISSING_DET_EN to add the o_pps_missing watchdog that stops running channels on PPS loss.
module pps_channel_scheduler #(
    parameter int N_CH      = 4,
    parameter int CH_AW     = 2,
    parameter int SEC_WIDTH = 32
) (
    input  logic                 i_clk_10,
    input  logic                 i_rst_n,
    input  logic                 i_pps_raw,
    input  logic                 i_arm,
    input  logic [CH_AW-1:0]     i_ch,
    input  logic [SEC_WIDTH-1:0] i_start_sec,
    input  logic [SEC_WIDTH-1:0] i_stop_sec,
    input  logic [N_CH-1:0]      i_abort,
    input  logic                 i_sec_load,
    input  logic [SEC_WIDTH-1:0] i_sec_value,
    output logic [N_CH-1:0]      o_start,
    output logic [N_CH-1:0]      o_stop,
    output logic [SEC_WIDTH-1:0] o_sec_count,
    output logic [N_CH-1:0]      o_ch_running,
    output logic                 o_arm_err
`ifdef PPS_MISSING_DET_EN
    ,
    output logic                 o_pps_missing
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUNNING, ST_DONE} ch_state_t;

    ch_state_t            state    [N_CH];
    ch_state_t            state_nx [N_CH];
    logic [SEC_WIDTH-1:0] start_sec [N_CH];
    logic [SEC_WIDTH-1:0] stop_sec  [N_CH];

    logic            pps_meta, pps_sync, pps_prev, pps_tick;
    // Delayed tick: the counter already shows the new second, so channels
    // switch one cycle after the count reaches their scheduled value.
    logic            pps_tick_d;
    logic [N_CH-1:0] arm_sel;
    logic            sched_ok, arm_cancel, arm_err_nx, wd_trip;

`ifdef PPS_MISSING_DET_EN
    localparam logic [23:0] WD_LIMIT = 24'd10_500_000;
    logic [23:0] wd_count;
    assign wd_trip = !o_pps_missing && !pps_tick && (wd_count == WD_LIMIT - 24'd1);
`else
    assign wd_trip = 1'b0;
`endif

    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin
        arm_sel = '0;
        if (i_arm && int'(i_ch) < N_CH) arm_sel[i_ch] = 1'b1;
        // Widen by one bit so count+1 cannot wrap and let a stale start slip through.
        sched_ok = ({1'b0, i_start_sec} > ({1'b0, o_sec_count} + (SEC_WIDTH+1)'(1)))
                   && (i_stop_sec == '0 || i_stop_sec > i_start_sec);
        arm_cancel = i_sec_load && (i_start_sec <= i_sec_value);
        arm_err_nx = i_arm && (int'(i_ch) >= N_CH);

        for (int k = 0; k < N_CH; k++) begin
            state_nx[k] = state[k];
            case (state[k])
                ST_IDLE, ST_DONE: begin
                    if (arm_sel[k]) begin
                        if (sched_ok && !arm_cancel) state_nx[k] = ST_ARMED;
                        else                         arm_err_nx  = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (arm_sel[k]) arm_err_nx = 1'b1;
                    if (i_sec_load) begin
                        if (start_sec[k] <= i_sec_value) begin
                            state_nx[k] = ST_IDLE;
                            arm_err_nx  = 1'b1;
                        end
                    end else if (pps_tick_d && o_sec_count == start_sec[k]) begin
                        state_nx[k] = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (arm_sel[k]) arm_err_nx = 1'b1;
                    if (i_sec_load) begin
                        if (stop_sec[k] != '0 && stop_sec[k] <= i_sec_value) state_nx[k] = ST_DONE;
                    end else if (pps_tick_d && stop_sec[k] != '0 && o_sec_count == stop_sec[k]) begin
                        state_nx[k] = ST_DONE;
                    end
                end
                default: state_nx[k] = ST_IDLE;
            endcase
            if (wd_trip && state_nx[k] == ST_RUNNING) state_nx[k] = ST_DONE;
            if (i_abort[k] && state[k] != ST_IDLE)    state_nx[k] = ST_DONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pps_meta     <= 1'b0;
            pps_sync     <= 1'b0;
            pps_prev     <= 1'b0;
            pps_tick     <= 1'b0;
            pps_tick_d   <= 1'b0;
            o_sec_count  <= '0;
            o_start      <= '0;
            o_stop       <= '1;
            o_ch_running <= '0;
            o_arm_err    <= 1'b0;
            // NOTE: the schedule registers are a handful of flops, not a RAM, so they are reset too.
            for (int k = 0; k < N_CH; k++) begin
                state[k]     <= ST_IDLE;
                start_sec[k] <= '0;
                stop_sec[k]  <= '0;
            end
        end else begin
            pps_meta   <= i_pps_raw;
            pps_sync   <= pps_meta;
            pps_prev   <= pps_sync;
            pps_tick   <= pps_sync & ~pps_prev;
            pps_tick_d <= pps_tick & ~i_sec_load;

            if (i_sec_load)    o_sec_count <= i_sec_value;
            else if (pps_tick) o_sec_count <= o_sec_count + SEC_WIDTH'(1);

            for (int k = 0; k < N_CH; k++) begin
                state[k]        <= state_nx[k];
                o_start[k]      <= (state_nx[k] == ST_RUNNING);
                o_ch_running[k] <= (state_nx[k] == ST_RUNNING);
                o_stop[k]       <= (state_nx[k] == ST_IDLE) || (state_nx[k] == ST_DONE);
                if (state_nx[k] == ST_ARMED && state[k] != ST_ARMED) begin
                    start_sec[k] <= i_start_sec;
                    stop_sec[k]  <= i_stop_sec;
                end
            end
            o_arm_err <= arm_err_nx;
        end
    end

`ifdef PPS_MISSING_DET_EN
    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_count      <= '0;
            o_pps_missing <= 1'b0;
        end else if (pps_tick) begin
            wd_count      <= '0;
            o_pps_missing <= 1'b0;
        end else if (!o_pps_missing) begin
            wd_count <= wd_count + 24'd1;
            if (wd_trip) o_pps_missing <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pps_channel_scheduler.sv
// Directed bench for pps_channel_scheduler: table of arm checks plus PPS-driven sequences.
module tb_pps_channel_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pps_raw;
    logic        arm;
    logic [1:0]  ch;
    logic [31:0] start_sec, stop_sec;
    logic [3:0]  abort;
    logic        sec_load;
    logic [31:0] sec_value;
    logic [3:0]  start_o, stop_o, running;
    logic [31:0] sec_count;
    logic        arm_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pps_channel_scheduler #(.N_CH(4), .CH_AW(2), .SEC_WIDTH(32)) dut (
        .i_clk_10    (clk),
        .i_rst_n     (rst_n),
        .i_pps_raw   (pps_raw),
        .i_arm       (arm),
        .i_ch        (ch),
        .i_start_sec (start_sec),
        .i_stop_sec  (stop_sec),
        .i_abort     (abort),
        .i_sec_load  (sec_load),
        .i_sec_value (sec_value),
        .o_start     (start_o),
        .o_stop      (stop_o),
        .o_sec_count (sec_count),
        .o_ch_running(running),
        .o_arm_err   (arm_err)
    );

    typedef struct packed {
        logic [31:0] count;
        logic [1:0]  ch;
        logic [31:0] start;
        logic [31:0] stop;
        logic        accept;
    } arm_vec_t;

    arm_vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sec(input logic [31:0] v);
        sec_load  = 1'b1;
        sec_value = v;
        step();
        sec_load  = 1'b0;
    endtask

    task automatic do_arm(input logic [1:0] c, input logic [31:0] s, input logic [31:0] p);
        arm       = 1'b1;
        ch        = c;
        start_sec = s;
        stop_sec  = p;
        step();
        arm       = 1'b0;
    endtask

    // Raise PPS and wait (bounded) until the counter shows the target second.
    task automatic pps_advance(input logic [31:0] target);
        bit hit;
        hit = 1'b0;
        pps_raw = 1'b1;
        for (int n = 0; n < 8 && !hit; n++) begin
            step();
            if (sec_count == target) hit = 1'b1;
        end
        check("pps_count", sec_count, target);
    endtask

    task automatic pps_release();
        pps_raw = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst_n = 1'b0; pps_raw = 1'b0; arm = 1'b0; ch = '0; start_sec = '0; stop_sec = '0;
        abort = '0; sec_load = 1'b0; sec_value = '0;

        vecs[0]  = '{32'd2,          2'd1, 32'd3,          32'd0,  1'b0};
        vecs[1]  = '{32'd2,          2'd1, 32'd4,          32'd0,  1'b1};
        vecs[2]  = '{32'd2,          2'd0, 32'd5,          32'd8,  1'b1};
        vecs[3]  = '{32'd2,          2'd0, 32'd5,          32'd5,  1'b0};
        vecs[4]  = '{32'd2,          2'd0, 32'd5,          32'd4,  1'b0};
        vecs[5]  = '{32'd10,         2'd3, 32'd12,         32'd0,  1'b1};
        vecs[6]  = '{32'd10,         2'd3, 32'd11,         32'd20, 1'b0};
        vecs[7]  = '{32'd0,          2'd2, 32'd1,          32'd0,  1'b0};
        vecs[8]  = '{32'd0,          2'd2, 32'd2,          32'd3,  1'b1};
        vecs[9]  = '{32'd100,        2'd1, 32'd50,         32'd0,  1'b0};
        vecs[10] = '{32'hFFFF_FFF0,  2'd1, 32'hFFFF_FFFF,  32'd0,  1'b1};
        vecs[11] = '{32'hFFFF_FFFE,  2'd1, 32'hFFFF_FFFF,  32'd0,  1'b0};

        repeat (2) step();
        check("rst_start",   start_o,   4'b0000);
        check("rst_stop",    stop_o,    4'b1111);
        check("rst_count",   sec_count, 32'd0);
        check("rst_running", running,   4'b0000);
        check("rst_err",     arm_err,   1'b0);
        rst_n = 1'b1;
        step();

        // Arm acceptance table: load count, arm, check, then abort back to DONE.
        for (int i = 0; i < 12; i++) begin
            load_sec(vecs[i].count);
            check("tbl_count", sec_count, vecs[i].count);
            do_arm(vecs[i].ch, vecs[i].start, vecs[i].stop);
            check("tbl_err",   arm_err, !vecs[i].accept);
            check("tbl_armed", stop_o[vecs[i].ch], !vecs[i].accept);
            abort[vecs[i].ch] = 1'b1;
            step();
            abort = '0;
            check("tbl_err_clr", arm_err, 1'b0);
        end

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // ch0 runs seconds 5..8, ch2 starts at 4 with no stop.
        load_sec(32'd2);
        do_arm(2'd0, 32'd5, 32'd8);
        check("arm0_err", arm_err, 1'b0);
        do_arm(2'd2, 32'd4, 32'd0);
        check("armed_stop", stop_o, 4'b1010);
        pps_advance(32'd3);
        check("armed_start", start_o, 4'b0000);
        pps_release();
        pps_advance(32'd4);
        check("ch2_not_yet", start_o, 4'b0000);
        step();
        check("ch2_start", start_o, 4'b0100);
        pps_release();
        pps_advance(32'd5);
        check("ch0_not_yet", start_o[0], 1'b0);
        step();
        check("ch0_start",   start_o, 4'b0101);
        check("ch0_running", running, 4'b0101);
        check("ch0_stop_lo", stop_o,  4'b1010);
        pps_release();
        pps_advance(32'd6); pps_release();
        pps_advance(32'd7); pps_release();
        pps_advance(32'd8);
        check("ch0_still_on", start_o[0], 1'b1);
        step();
        check("ch0_done_start", start_o, 4'b0100);
        check("ch0_done_stop",  stop_o,  4'b1011);
        pps_release();
        for (int s = 9; s <= 21; s++) begin
            pps_advance(32'(s));
            pps_release();
        end
        check("ch2_run_21", running, 4'b0100);
        abort[2] = 1'b1;
        step();
        abort = '0;
        check("abort_start",   start_o, 4'b0000);
        check("abort_stop",    stop_o,  4'b1111);
        check("abort_running", running, 4'b0000);

        // Load coincident with PPS tick cancels ARMED ch0; a bad arm in the same cycle adds no second pulse.
        load_sec(32'd5);
        do_arm(2'd0, 32'd10, 32'd0);
        check("c_armed", stop_o[0], 1'b0);
        pps_raw = 1'b1;
        repeat (3) step();
        sec_load = 1'b1; sec_value = 32'd12;
        arm = 1'b1; ch = 2'd1; start_sec = 32'd3; stop_sec = 32'd0;
        step();
        sec_load = 1'b0; arm = 1'b0;
        check("c_count",    sec_count, 32'd12);
        check("c_err",      arm_err,   1'b1);
        check("c_ch0_idle", stop_o,    4'b1111);
        step();
        check("c_err_once", arm_err,   1'b0);
        pps_release();
        check("c_count_hold", sec_count, 32'd12);

        // Asynchronous reset while ch3 is RUNNING.
        do_arm(2'd3, 32'd14, 32'd0);
        pps_advance(32'd13); pps_release();
        pps_advance(32'd14);
        step();
        check("e_running", running, 4'b1000);
        pps_release();
        #3;
        rst_n = 1'b0;
        #1;
        check("e_start",   start_o,   4'b0000);
        check("e_stop",    stop_o,    4'b1111);
        check("e_count",   sec_count, 32'd0);
        check("e_running", running,   4'b0000);
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pps_channel_scheduler.md
Name: pps_channel_scheduler

Overview:
Schedules the start/stop control of N pps_divider channels against an absolute PPS second count, so several divided outputs launch and terminate on chosen seconds. Sits between the host register file and the pps_divider instances; drives each divider's start/stop levels and keeps the shared seconds counter. Host arms a channel with start/stop seconds; the block sequences the channel with no further host timing.

Parameters:
N_CH, 4, number of pps_divider channels controlled
CH_AW, 2, channel index width (clog2(N_CH))
SEC_WIDTH, 32, seconds counter and schedule field width

Ports:
i_clk_10  in  1  10 MHz system clock
i_rst_n  in  1  asynchronous active-low reset
i_pps_raw  in  1  raw PPS input (asynchronous)
i_arm  in  1  one-cycle arm request for channel i_ch
i_ch  in  CH_AW  target channel for i_arm
i_start_sec  in  SEC_WIDTH  second at which channel starts
i_stop_sec  in  SEC_WIDTH  second at which channel stops; 0 = no scheduled stop
i_abort  in  N_CH  per-channel abort, level, sampled each cycle
i_sec_load  in  1  one-cycle load of seconds counter
i_sec_value  in  SEC_WIDTH  value for i_sec_load
o_start  out  N_CH  per-channel start level to pps_divider i_start
o_stop  out  N_CH  per-channel stop level to pps_divider i_stop
o_sec_count  out  SEC_WIDTH  current seconds count
o_ch_running  out  N_CH  channel in RUNNING
o_arm_err  out  1  one-cycle pulse: arm or load rejected/cancelled a schedule

Behaviour:
- Reset (async, i_rst_n=0): o_sec_count=0, all channels IDLE, o_start=0, o_stop=all ones, o_ch_running=0, o_arm_err=0.
- PPS edge: i_pps_raw through 2-FF synchroniser, then edge register; pps_tick = 1-cycle pulse on synchronised 0->1. Latency raw rise -> pps_tick = 3 cycles.
- Seconds counter: +1 on pps_tick, wraps modulo 2^SEC_WIDTH. i_sec_load sets o_sec_count=i_sec_value next cycle; load and pps_tick same cycle -> load wins, increment dropped.
- Per-channel FSM, states IDLE, ARMED, RUNNING, DONE:
  - IDLE/DONE: o_start=0, o_stop=1. i_arm to this channel accepted iff i_start_sec > o_sec_count+1 (unsigned, current-cycle value) and (i_stop_sec==0 or i_stop_sec > i_start_sec); accepted -> latch start/stop, ARMED next cycle. Rejected -> o_arm_err pulse next cycle, state unchanged.
  - ARMED: o_start=0, o_stop=0. On pps_tick where o_sec_count+1 == start_sec -> RUNNING next cycle (o_start rises 1 cycle after counter reaches start_sec). Divider's first acted-on PPS is the one advancing count to start_sec+1.
  - RUNNING: o_start=1, o_stop=0. On pps_tick where stop_sec!=0 and o_sec_count+1 == stop_sec -> DONE.
  - i_arm to ARMED or RUNNING channel: rejected, o_arm_err pulse.
- i_abort[k]=1: channel k -> DONE next cycle from any state except IDLE; abort overrides arm/tick same cycle.
- i_sec_load: every ARMED channel with start_sec <= i_sec_value -> IDLE, o_arm_err pulse. RUNNING channels with stop_sec!=0 and stop_sec <= i_sec_value -> DONE. No error for RUNNING.
- One arm per cycle; simultaneous arm-reject and load-cancel produce a single o_arm_err pulse.
- Wrap: equality compare only in ARMED/RUNNING; schedules crossing the 2^SEC_WIDTH wrap are not supported (arm check is unsigned).
- o_ch_running[k] = (state==RUNNING); all outputs registered.

Optional Feature:
PPS_MISSING_DET_EN: adds output o_pps_missing (1 bit, reset 0) and a 24-bit watchdog counting i_clk_10 cycles since last pps_tick; reaching 10_500_000 sets o_pps_missing (sticky) and forces every RUNNING channel to DONE; next pps_tick clears o_pps_missing and watchdog. Without the macro: port absent, no watchdog, channels unaffected by PPS loss.

Test Plan:
- Arm ch0 start=5 stop=8 at count 2; PPS every 10_000_000 clk -> o_start[0] rises 1 cycle after count=5, falls and o_stop[0]=1 1 cycle after count=8.
- Arm ch1 start=3 at count 2 -> rejected, o_arm_err 1 pulse, ch1 stays IDLE; start=4 accepted.
- Arm ch2 start=4 stop=0 -> RUNNING indefinitely past count 20; i_abort[2] -> o_start[2]=0, o_stop[2]=1 next cycle.
- Ch0 ARMED start=10, i_sec_load value=12 coincident with pps_tick -> count=12 (not 13), ch0 IDLE, one o_arm_err pulse.
- Assert i_rst_n=0 mid-RUNNING without clock edge -> o_start=0, o_stop=all ones, count=0 immediately.
- With PPS_MISSING_DET_EN: ch3 RUNNING, stop PPS -> o_pps_missing=1 at 10_500_000 cycles, ch3 DONE; next PPS clears flag.
